keypad_matrix_scanner: RTL and testbench

Parametrised, debounced matrix-keypad scanner with a buffered event output. It drives active-low rows and samples active-low columns for any ROWS×COLS matrix. Presses must hold for several whole frames before they register. Each debounced press becomes an event word in a small first-word-fall-through FIFO, read with a valid/ready handshake. It sits between the board keypad pins and the application logic and replaces the fixed 4×4 single-pulse scanner.

---
 rtl/keypad_matrix_scanner.sv | 208 ++++++++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: debounced ROWSxCOLS keypad scanner with event FIFO.
// Ports: clk, rst (async high); row (active-low drive), col (active-low sense);
//   out_data/out_valid/out_ready event stream; key_down/key_code held key;
//   overflow (sticky drop flag); fifo_count (stored events).
// Option: define KEYPAD_RELEASE_EVENT_EN for release events (MSB=1).
module keypad_matrix_scanner #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_TICKS     = 100000,
  parameter int SETTLE_TICKS   = 100,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int FIFO_DEPTH     = 4,
  localparam int CODE_W        = $clog2(ROWS * COLS),
`ifdef KEYPAD_RELEASE_EVENT_EN
  localparam int EW            = CODE_W + 1,
`else
  localparam int EW            = CODE_W,
`endif
  localparam int CW            = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ROWS-1:0]   row,
  input  logic [COLS-1:0]   col,
  output logic [EW-1:0]     out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              key_down,
  output logic [CODE_W-1:0] key_code,
  output logic              overflow,
  output logic [CW:0]       fifo_count
);

  localparam int TW = $clog2(SCAN_TICKS);
  localparam int RW = $clog2(ROWS);

  typedef enum logic {EV_IDLE, EV_PRESS} ev_t;

  logic [COLS-1:0]   col_s1, col_s2;
  logic [TW-1:0]     tick;
  logic [RW-1:0]     r;
  logic              hit_valid, prev_valid, upd, upd_valid, deb_valid;
  logic [CODE_W-1:0] hit_code, prev_code, upd_code, deb_code;
  logic [3:0]        stable, new_cnt;
  logic              tick_last, sample, frame_end, same, diff_deb;
  logic              col_hit;
  logic [CODE_W-1:0] samp_code;
  ev_t               ev_state, ev_next;
  logic              push, pop, full, wr_en;
  logic [EW-1:0]     push_data;
  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [CW-1:0]     wr_ptr, rd_ptr;
  logic [CW:0]       count;

  assign tick_last = tick == TW'(SCAN_TICKS - 1);
  assign sample    = tick == TW'(SETTLE_TICKS);
  assign frame_end = tick_last && (r == RW'(ROWS - 1));

  // Lowest low column in the current row wins.
  always_comb begin
    col_hit   = 1'b0;
    samp_code = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!col_s2[c]) begin
        col_hit   = 1'b1;
        samp_code = CODE_W'(int'(r) * COLS + c);
      end
    end
  end

  always_comb begin
    same = (hit_valid == prev_valid) &&
           (!hit_valid || hit_code == prev_code);
    diff_deb = (hit_valid != deb_valid) ||
               (hit_valid && hit_code != deb_code);
    if (!same)
      new_cnt = 4'd1;
    else if (stable == 4'hF)
      new_cnt = stable;
    else
      new_cnt = stable + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1     <= '1;
      col_s2     <= '1;
      tick       <= '0;
      r          <= '0;
      row        <= '1;
      hit_valid  <= 1'b0;
      hit_code   <= '0;
      prev_valid <= 1'b0;
      prev_code  <= '0;
      stable     <= '0;
      upd        <= 1'b0;
      upd_valid  <= 1'b0;
      upd_code   <= '0;
      deb_valid  <= 1'b0;
      deb_code   <= '0;
    end else begin
      col_s1 <= col;
      col_s2 <= col_s1;
      row    <= ~(ROWS'(1) << r);
      tick   <= tick_last ? '0 : tick + TW'(1);
      if (tick_last)
        r <= (r == RW'(ROWS - 1)) ? '0 : r + RW'(1);
      if (sample && !hit_valid && col_hit) begin
        hit_valid <= 1'b1;
        hit_code  <= samp_code;
      end
      upd <= 1'b0;
      if (frame_end) begin
        hit_valid  <= 1'b0;
        hit_code   <= '0;
        prev_valid <= hit_valid;
        prev_code  <= hit_code;
        stable     <= new_cnt;
        if (new_cnt >= 4'(DEBOUNCE_SCANS) && diff_deb) begin
          upd       <= 1'b1;
          upd_valid <= hit_valid;
          upd_code  <= hit_code;
        end
      end
      if (upd) begin
        deb_valid <= upd_valid;
        if (upd_valid)
          deb_code <= upd_code;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ev_state <= EV_IDLE;
    else
      ev_state <= ev_next;
  end

  // deb_* still holds the old state during the upd cycle.
  always_comb begin
    ev_next   = ev_state;
    push      = 1'b0;
    push_data = '0;
    unique case (ev_state)
      EV_IDLE: begin
        if (upd) begin
`ifdef KEYPAD_RELEASE_EVENT_EN
          if (deb_valid) begin
            push      = 1'b1;
            push_data = {1'b1, deb_code};
            if (upd_valid)
              ev_next = EV_PRESS;
          end else if (upd_valid) begin
            push      = 1'b1;
            push_data = EW'(upd_code);
          end
`else
          if (upd_valid) begin
            push      = 1'b1;
            push_data = EW'(upd_code);
          end
`endif
        end
      end
      EV_PRESS: begin
        push      = 1'b1;
        push_data = EW'(upd_code);
        ev_next   = EV_IDLE;
      end
    endcase
  end

  assign out_valid  = count != '0;
  assign full       = count == (CW+1)'(FIFO_DEPTH);
  assign pop        = out_valid && out_ready;
  assign wr_en      = push && (!full || pop);
  assign out_data   = mem[rd_ptr];
  assign fifo_count = count;
  assign key_down   = deb_valid;
  assign key_code   = deb_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + CW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + CW'(1);
      unique case ({wr_en, pop})
        2'b10:   count <= count + (CW+1)'(1);
        2'b01:   count <= count - (CW+1)'(1);
        default: count <= count;
      endcase
      if (push && full && !pop)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: scoreboard bench for keypad_matrix_scanner.
// Keypad modelled as a key mask shorting rows to columns.
module tb_keypad_matrix_scanner;

  localparam int CODE_W = 4;
`ifdef KEYPAD_RELEASE_EVENT_EN
  localparam int EW = 5;
`else
  localparam int EW = 4;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [3:0]        row;
  logic [3:0]        col;
  logic [EW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              key_down;
  logic [CODE_W-1:0] key_code;
  logic              overflow;
  logic [2:0]        fifo_count;
  logic [15:0]       keys = '0;

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  int model_cnt = 0;
  bit cur_valid = 1'b0;
  logic [3:0] cur_code = '0;
  logic [EW-1:0] q[$];
  logic [EW-1:0] mexp;

  keypad_matrix_scanner #(
    .ROWS(4), .COLS(4), .SCAN_TICKS(16), .SETTLE_TICKS(4),
    .DEBOUNCE_SCANS(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .key_down(key_down), .key_code(key_code), .overflow(overflow),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    col = '1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (!row[i] && keys[i*4+j])
          col[j] = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      pops++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event got=%h", out_data);
      end else begin
        mexp = q.pop_front();
        if (out_data !== mexp) begin
          errors++;
          $display("FAIL event_data got=%h exp=%h", out_data, mexp);
        end
      end
    end
  end

  function automatic logic [EW-1:0] ev_press(input logic [3:0] c);
    return EW'(c);
  endfunction

`ifdef KEYPAD_RELEASE_EVENT_EN
  function automatic logic [EW-1:0] ev_rel(input logic [3:0] c);
    return {1'b1, c};
  endfunction
`endif

  task automatic queue_ev(input logic [EW-1:0] e);
    if (out_ready) begin
      q.push_back(e);
    end else if (model_cnt < 4) begin
      q.push_back(e);
      model_cnt++;
    end
  endtask

  task automatic expect_change(input bit nv, input logic [3:0] nc);
    if (nv == cur_valid && (!nv || nc == cur_code))
      return;
`ifdef KEYPAD_RELEASE_EVENT_EN
    if (cur_valid)
      queue_ev(ev_rel(cur_code));
`endif
    if (nv)
      queue_ev(ev_press(nc));
    cur_valid = nv;
    if (nv)
      cur_code = nc;
  endtask

  // Leaves the bench #1 into the cycle in which a frame-end push lands.
  task automatic to_push_cycle();
    int n;
    logic [3:0] pr;
    n = 0;
    @(negedge clk);
    pr = row;
    forever begin
      @(negedge clk);
      n++;
      if (row == 4'b0111 && pr != 4'b0111)
        break;
      pr = row;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL frame_timeout row=%b exp=0111", row);
        return;
      end
    end
    repeat (15) @(posedge clk);
    #1;
  endtask

  task automatic hold_key(input logic [15:0] m, input bit nv,
                          input logic [3:0] nc, input int frames);
    to_push_cycle();
    keys = m;
    expect_change(nv, nc);
    repeat (frames) to_push_cycle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    keys = '0;
    out_ready = 1'b0;
    q.delete();
    cur_valid = 1'b0;
    model_cnt = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] er;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (row !== 4'b1111 || out_valid !== 1'b0 || overflow !== 1'b0 ||
        fifo_count !== 3'd0 || key_down !== 1'b0 ||
        key_code !== 4'd0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_values row=%b v=%b ovf=%b cnt=%0d kd=%b kc=%0d d=%h exp=1111/0/0/0/0/0/0",
               row, out_valid, overflow, fifo_count, key_down, key_code, out_data);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (row !== 4'b1111) begin
      errors++;
      $display("FAIL row_first got=%b exp=1111", row);
    end
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      er = ~(4'b0001 << ((i - 1) / 16));
      checks++;
      if (row !== er) begin
        errors++;
        $display("FAIL row_scan i=%0d got=%b exp=%b", i, row, er);
      end
    end
  endtask

  task automatic test_single_press();
    int p0;
    out_ready = 1'b1;
    p0 = pops;
    hold_key(16'h1 << 9, 1'b1, 4'd9, 5);
    checks++;
    if (pops - p0 !== 1 || q.size() != 0) begin
      errors++;
      $display("FAIL single_events got=%0d left=%0d exp=1", pops - p0, q.size());
    end
    checks++;
    if (key_down !== 1'b1 || key_code !== 4'd9) begin
      errors++;
      $display("FAIL single_key kd=%b kc=%0d exp=1/9", key_down, key_code);
    end
    hold_key(16'h0, 1'b0, 4'd0, 5);
    checks++;
    if (key_down !== 1'b0 || key_code !== 4'd9) begin
      errors++;
      $display("FAIL release_hold kd=%b kc=%0d exp=0/9", key_down, key_code);
    end
  endtask

  task automatic test_bounce();
    int p0;
    out_ready = 1'b1;
    p0 = pops;
    for (int i = 0; i < 6; i++) begin
      to_push_cycle();
      keys = (i % 2 == 0) ? (16'h1 << 3) : 16'h0;
    end
    to_push_cycle();
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (key_down !== 1'b0 || pops != p0) begin
      errors++;
      $display("FAIL bounce_reject kd=%b events=%0d exp=0/0", key_down, pops - p0);
    end
    hold_key(16'h1 << 3, 1'b1, 4'd3, 5);
    checks++;
    if (pops - p0 != 1 || key_code !== 4'd3 || q.size() != 0) begin
      errors++;
      $display("FAIL bounce_accept events=%0d kc=%0d exp=1/3", pops - p0, key_code);
    end
    hold_key(16'h0, 1'b0, 4'd0, 5);
  endtask

  task automatic test_overflow();
    int codes[5] = '{1, 2, 4, 7, 8};
    out_ready = 1'b0;
    model_cnt = 0;
    foreach (codes[i])
      hold_key(16'h1 << codes[i], 1'b1, 4'(codes[i]), 4);
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL overflow_state cnt=%0d ovf=%b v=%b exp=4/1/1",
               fifo_count, overflow, out_valid);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (out_data !== q[0]) begin
      errors++;
      $display("FAIL head_stable got=%h exp=%h", out_data, q[0]);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL drain left=%0d cnt=%0d exp=0/0", q.size(), fifo_count);
    end
    model_cnt = 0;
    hold_key(16'h0, 1'b0, 4'd0, 4);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky got=%b exp=1", overflow);
    end
    apply_reset();
  endtask

  task automatic test_midscan_reset();
    out_ready = 1'b0;
    model_cnt = 0;
    hold_key(16'h1 << 5, 1'b1, 4'd5, 4);
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (row !== 4'b1111 || fifo_count !== 3'd0 || out_valid !== 1'b0 ||
        key_down !== 1'b0) begin
      errors++;
      $display("FAIL midscan_reset row=%b cnt=%0d v=%b kd=%b exp=1111/0/0/0",
               row, fifo_count, out_valid, key_down);
    end
    apply_reset();
  endtask

  task automatic test_multikey_handshake();
    int p0;
    out_ready = 1'b0;
    model_cnt = 0;
    hold_key((16'h1 << 6) | (16'h1 << 13), 1'b1, 4'd6, 4);
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd1 || out_data !== ev_press(4'd6)) begin
      errors++;
      $display("FAIL multikey cnt=%0d d=%h exp=1/%h", fifo_count, out_data, ev_press(4'd6));
    end
`ifdef KEYPAD_RELEASE_EVENT_EN
    hold_key(16'h1 << 1, 1'b1, 4'd1, 4);
    hold_key(16'h0, 1'b0, 4'd0, 4);
`else
    hold_key(16'h1 << 1, 1'b1, 4'd1, 4);
    hold_key(16'h1 << 2, 1'b1, 4'd2, 4);
    hold_key(16'h1 << 4, 1'b1, 4'd4, 4);
`endif
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill cnt=%0d ovf=%b exp=4/0", fifo_count, overflow);
    end
    to_push_cycle();
    keys = 16'h1 << 8;
    cur_valid = 1'b1;
    cur_code = 4'd8;
    q.push_back(ev_press(4'd8));
    repeat (3) to_push_cycle();
    p0 = pops;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0 || pops - p0 != 1) begin
      errors++;
      $display("FAIL full_push_pop cnt=%0d ovf=%b pops=%0d exp=4/0/1",
               fifo_count, overflow, pops - p0);
    end
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL hs_drain left=%0d cnt=%0d exp=0/0", q.size(), fifo_count);
    end
    hold_key(16'h0, 1'b0, 4'd0, 4);
  endtask

`ifdef KEYPAD_RELEASE_EVENT_EN
  task automatic test_release();
    int p0;
    out_ready = 1'b1;
    p0 = pops;
    hold_key(16'h1 << 5, 1'b1, 4'd5, 4);
    hold_key(16'h0, 1'b0, 4'd0, 4);
    checks++;
    if (pops - p0 != 2 || q.size() != 0) begin
      errors++;
      $display("FAIL release_events got=%0d exp=2", pops - p0);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_overflow();
    test_midscan_reset();
    test_multikey_handshake();
`ifdef KEYPAD_RELEASE_EVENT_EN
    test_release();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
